mc_ctrl: RTL

Multi-cycle main controller for the single-issue MIPS-subset datapath. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every datapath strobe and mux select (including the immediate extender's `EOp`), handshakes with a shared instruction/data memory port, and counts retired instructions. It sits beside the IR and owns no datapath registers itself.

---
 rtl/mc_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle main controller for the MIPS-subset datapath. Walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives every datapath strobe
// and mux select, handshakes with the shared instruction/data memory port and
// counts retired instructions.
//
// Ports
//   clk        in  1   rising-edge clock
//   rst_n      in  1   asynchronous active-low reset
//   instr      in  32  current IR contents
//   zero       in  1   ALU result is zero
//   mem_ready  in  1   memory completes the pending access this cycle
//   mem_req    out 1   memory access request
//   mem_we     out 1   memory access is a write
//   ir_we      out 1   IR load strobe
//   pc_we      out 1   PC load strobe
//   pc_src     out 2   PC source select
//   EOp        out 2   immediate extender mode
//   alu_op     out 2   ALU operation
//   alu_b_src  out 1   ALU B operand select
//   reg_we     out 1   register file write strobe
//   reg_dst    out 2   register file destination select
//   wd_src     out 2   register file write data select
//   illegal    out 1   pulse on an undecodable instruction
//   state      out 3   current state
//   instr_cnt  out 32  retired-instruction count
// -----------------------------------------------------------------------------
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  EOp,
  output logic [1:0]  alu_op,
  output logic        alu_b_src,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_src,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr_cnt;
  logic        w_retire;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic        w_isR;
  logic        w_isNop;
  logic        w_isAddu;
  logic        w_isSubu;
  logic        w_isJr;
  logic        w_isOri;
  logic        w_isLui;
  logic        w_isLw;
  logic        w_isSw;
  logic        w_isBeq;
  logic        w_isJ;
  logic        w_isJal;
  logic        w_isIllegal;

  // Instruction classification. A zero word is nop, so R-type decoding
  // only claims non-zero words with a recognised funct.
  always_comb begin
    w_opcode    = instr[31:26];
    w_funct     = instr[5:0];
    w_isNop     = (instr == 32'd0);
    w_isR       = (w_opcode == 6'b000000) && !w_isNop;
    w_isAddu    = w_isR && (w_funct == 6'b100001);
    w_isSubu    = w_isR && (w_funct == 6'b100011);
    w_isJr      = w_isR && (w_funct == 6'b001000);
    w_isOri     = (w_opcode == 6'b001101);
    w_isLui     = (w_opcode == 6'b001111);
    w_isLw      = (w_opcode == 6'b100011);
    w_isSw      = (w_opcode == 6'b101011);
    w_isBeq     = (w_opcode == 6'b000100);
    w_isJ       = (w_opcode == 6'b000010);
    w_isJal     = (w_opcode == 6'b000011);
    w_isIllegal = !(w_isNop || w_isAddu || w_isSubu || w_isJr || w_isOri ||
                    w_isLui || w_isLw || w_isSw || w_isBeq || w_isJ || w_isJal);
  end

  // Datapath selects depend only on the instruction, so they are valid in
  // every state and the datapath can settle before the state that uses them.
  always_comb begin
    EOp       = 2'b00;
    alu_op    = 2'b00;
    alu_b_src = 1'b0;
    reg_dst   = 2'b00;
    wd_src    = 2'b00;
    if (w_isAddu) begin
      reg_dst = 2'b01;
    end
    if (w_isSubu) begin
      alu_op  = 2'b01;
      reg_dst = 2'b01;
    end
    if (w_isOri) begin
      EOp       = 2'b01;
      alu_op    = 2'b10;
      alu_b_src = 1'b1;
    end
    if (w_isLui) begin
      EOp       = 2'b10;
      alu_b_src = 1'b1;
    end
    if (w_isLw) begin
      alu_b_src = 1'b1;
      wd_src    = 2'b01;
    end
    if (w_isSw) begin
      alu_b_src = 1'b1;
    end
    if (w_isBeq) begin
      EOp    = 2'b11;
      alu_op = 2'b01;
    end
    if (w_isJal) begin
      reg_dst = 2'b10;
      wd_src  = 2'b10;
    end
  end

  // State register and retired-instruction counter. Reset forces FETCH
  // immediately, which also abandons any memory access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_instr_cnt <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  // Next-state and strobe logic. Every strobe except mem_req is gated by
  // rst_n so nothing loads while reset is held, even with mem_ready high.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'b00;
    reg_we   = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready && rst_n) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = DECODE;
        end
      end
      DECODE: begin
        if (w_isIllegal) begin
          illegal = rst_n;
          w_next  = FETCH;
        end else if (w_isNop) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end else if (w_isJ || w_isJal) begin
          pc_we    = rst_n;
          pc_src   = 2'b10;
          reg_we   = w_isJal && rst_n;
          w_next   = FETCH;
          w_retire = 1'b1;
        end else if (w_isJr) begin
          pc_we    = rst_n;
          pc_src   = 2'b11;
          w_next   = FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = EXEC;
        end
      end
      EXEC: begin
        if (w_isLw || w_isSw) begin
          w_next = MEM;
        end else if (w_isBeq) begin
          if (zero) begin
            pc_we  = rst_n;
            pc_src = 2'b01;
          end
          w_next   = FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = w_isSw && rst_n;
        if (mem_ready) begin
          if (w_isSw) begin
            w_next   = FETCH;
            w_retire = 1'b1;
          end else begin
            w_next = WB;
          end
        end
      end
      WB: begin
        reg_we   = rst_n;
        w_next   = FETCH;
        w_retire = 1'b1;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

  always_comb begin
    state     = r_state;
    instr_cnt = r_instr_cnt;
  end

endmodule
